line_instruction_cache: RTL and testbench
=========================================

LINE_INSTRUCTION_CACHE -- requirements
Module: line_instruction_cache

Interface
REQ-001 SHALL have parameter SETS, default 64, meaning number of cache lines (power of 2, >=2).
REQ-002 SHALL have parameter LINE_WORDS, default 4, meaning 32-bit words per line (power of 2, >=1).
REQ-003 SHALL have port clk_in  input  1  system clock; reset is asynchronous and active-low.
REQ-004 SHALL have port rst_n_in  input  1  async active-low reset.
REQ-005 SHALL have port rdy_in  input  1  when low, all state frozen and all inputs ignored.
REQ-006 SHALL have port flush_pipline  input  1  abort any refill and return to idle.
REQ-007 SHALL have port invalidate_all  input  1  clear every valid bit.
REQ-008 SHALL have port is_reading  input  1  lookup request.
REQ-009 SHALL have port read_addr  input  32  word-aligned fetch address; bits [1:0] ignored.
REQ-010 SHALL have port read_data  output  32  instruction for the last accepted read.
REQ-011 SHALL have port is_ready  output  1  idle, and read_data valid for the last accepted read.
REQ-012 SHALL have port request_ins_from_memory_adaptor  output  1  one-cycle word fetch pulse.
REQ-013 SHALL have port insaddr_to_be_fetched_from_memory_adaptor  output  32  word fetch address.
REQ-014 SHALL have port ins_fetched_from_memory_adaptor  input  32  fetched word.
REQ-015 SHALL have port insfetch_task_done  input  1  fetched word valid this cycle.

Function
REQ-016 SHALL decode the address as offset = [2+log2(LINE_WORDS)-1:2], index = next log2(SETS) bits, tag = remaining upper bits.
REQ-017 SHALL implement FSM states IDLE, REQ, WAIT, with all transitions on rising clk_in while rdy_in=1.
REQ-018 SHALL perform lookup only in IDLE with is_reading=1, hitting when valid[index]=1 and tag matches.
REQ-019 SHALL, on a hit, drive read_data with the word on the next cycle, keep is_ready=1 and issue no memory request.
REQ-020 SHALL, on a miss, on the next cycle drive is_ready=0, clear valid[index], latch the line base and requested offset, zero the word counter and enter REQ.
REQ-021 SHALL, in REQ, pulse request for exactly one cycle with address = line base + 4*counter, then enter WAIT.
REQ-022 SHALL, in WAIT with done=1, store the word at counter; if not the last word, increment the counter and enter REQ.
REQ-023 SHALL, when the last word (counter = LINE_WORDS-1) is stored, write the tag, set valid, drive read_data with the requested word (forwarded when it is the last word) and is_ready=1, then enter IDLE.
REQ-024 SHALL ignore insfetch_task_done in IDLE and REQ.
REQ-025 SHALL give flush_pipline priority over every other input: next cycle IDLE, request=0, is_ready=1, the partial line left invalid, and done in the same cycle dropped.
REQ-026 SHALL accept invalidate_all only in IDLE and clear all valid bits in one cycle; a simultaneous is_reading SHALL be evaluated as a miss.
REQ-027 SHALL ignore invalidate_all outside IDLE.
REQ-028 SHALL ignore is_reading outside IDLE.

Reset
REQ-029 SHALL, while rst_n_in=0, force state=IDLE, all valid bits=0, is_ready=1, read_data=0, request=0, fetch address=0 and counter=0, regardless of any operation in progress.
REQ-030 SHALL leave data and tag arrays uninitialised on reset.

Configuration
REQ-031 SHALL, when ICACHE_STATS_EN is defined, add output ports hit_count [31:0] and miss_count [31:0], reset to 0.
REQ-032 SHALL, with ICACHE_STATS_EN defined, increment hit_count or miss_count once per IDLE lookup, saturating at 32'hFFFFFFFF.
REQ-033 SHALL, when ICACHE_STATS_EN is undefined, have neither those ports nor any counter logic, with identical cache behaviour.

Verification (SETS=64, LINE_WORDS=4)
REQ-034 SHALL cover: cold read 0x104 -> requests 0x100, 0x104, 0x108, 0x10C in order; after the 4th done, is_ready=1 and read_data=mem[0x104]; then read 0x10C -> hit next cycle, no request.
REQ-035 SHALL cover: fill 0x100, then read 0x500 (index 16, different tag) -> 4-word refill; re-read 0x100 -> miss.
REQ-036 SHALL cover: flush in WAIT after the 2nd word -> next cycle is_ready=1, request=0; a late done is ignored; read 0x100 -> full 4-request refill.
REQ-037 SHALL cover: fill 0x000 and 0x100, pulse invalidate_all -> both subsequent reads miss.
REQ-038 SHALL cover: reset asserted in WAIT -> outputs immediately at reset values; read 0x104 after release -> miss.
REQ-039 SHALL cover, with ICACHE_STATS_EN: one miss at 0x0 plus reads 0x4, 0x8, 0xC -> hit_count=3, miss_count=1.

Source files
------------

// File: rtl/line_instruction_cache.sv
// line_instruction_cache
//
// Direct-mapped, read-only instruction cache with line-granular refill.
// A miss fetches the whole line one word at a time through a simple
// request/done handshake. When the last word arrives the cache returns the
// originally requested word.
//
// Optional feature macro: ICACHE_STATS_EN adds the hit/miss statistics
// counters and their output ports.
//
// Ports
//   clk_in                                     system clock
//   rst_n_in                                   asynchronous active-low reset
//   rdy_in                                     global enable; low freezes everything
//   flush_pipline                              abort refill, return to idle
//   invalidate_all                             clear all valid bits (idle only)
//   is_reading                                 lookup request
//   read_addr[31:0]                            fetch address (bits [1:0] ignored)
//   read_data[31:0]                            instruction for last accepted read
//   is_ready                                   idle and read_data valid
//   request_ins_from_memory_adaptor            one-cycle word fetch pulse
//   insaddr_to_be_fetched_from_memory_adaptor  word fetch address
//   ins_fetched_from_memory_adaptor[31:0]      fetched word
//   insfetch_task_done                         fetched word valid this cycle
//   hit_count[31:0], miss_count[31:0]          statistics (ICACHE_STATS_EN only)
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | accepting lookups and invalidate_all
// REQ   | issuing the fetch request for word 'cnt' of the refill line
// WAIT  | waiting for insfetch_task_done for word 'cnt'

module line_instruction_cache #(
    parameter int SETS       = 64,
    parameter int LINE_WORDS = 4
) (
    input  logic        clk_in,
    input  logic        rst_n_in,
    input  logic        rdy_in,
    input  logic        flush_pipline,
    input  logic        invalidate_all,
    input  logic        is_reading,
    input  logic [31:0] read_addr,
    output logic [31:0] read_data,
    output logic        is_ready,
    output logic        request_ins_from_memory_adaptor,
    output logic [31:0] insaddr_to_be_fetched_from_memory_adaptor,
    input  logic [31:0] ins_fetched_from_memory_adaptor,
    input  logic        insfetch_task_done
`ifdef ICACHE_STATS_EN
    ,
    output logic [31:0] hit_count,
    output logic [31:0] miss_count
`endif
);

    localparam int OFF_W = $clog2(LINE_WORDS);
    localparam int IDX_W = $clog2(SETS);
    localparam int CNT_W = (OFF_W > 0) ? OFF_W : 1;
    localparam int TAG_W = 30 - OFF_W - IDX_W;
    localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(LINE_WORDS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [SETS-1:0]  valid;
    logic [TAG_W-1:0] tag_mem  [SETS];
    logic [31:0]      data_mem [SETS][LINE_WORDS];

    logic [IDX_W-1:0] line_idx;
    logic [TAG_W-1:0] line_tag;
    logic [CNT_W-1:0] req_off;
    logic [CNT_W-1:0] cnt;
    logic [31:0]      fetch_addr;

    logic [IDX_W-1:0] rd_idx;
    logic [TAG_W-1:0] rd_tag;
    logic [CNT_W-1:0] rd_off;
    logic             unused_addr_bits;

    logic lookup;
    logic hit;
    logic miss;
    logic inv_en;
    logic fill_we;
    logic last_word;

    // ------------------------------------------------------------------
    // Address decode
    // ------------------------------------------------------------------
    assign rd_idx           = read_addr[2+OFF_W +: IDX_W];
    assign rd_tag           = read_addr[31 -: TAG_W];
    assign unused_addr_bits = ^read_addr[1:0];

    generate
        if (OFF_W > 0) begin : g_off
            assign rd_off = read_addr[2 +: OFF_W];
        end else begin : g_no_off
            assign rd_off = '0;
        end
    endgenerate

    // ------------------------------------------------------------------
    // Next-state and control decode
    // ------------------------------------------------------------------
    always_comb begin
        lookup    = 1'b0;
        hit       = 1'b0;
        miss      = 1'b0;
        inv_en    = 1'b0;
        fill_we   = 1'b0;
        last_word = (cnt == LAST_WORD);
        state_nxt = state;

        if (flush_pipline) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    lookup = is_reading;
                    inv_en = invalidate_all;
                    // A lookup coinciding with invalidate_all sees the
                    // post-invalidate view of the cache, so it must miss.
                    hit    = lookup && !invalidate_all && valid[rd_idx] &&
                             (tag_mem[rd_idx] == rd_tag);
                    miss   = lookup && !hit;
                    if (miss) begin
                        state_nxt = REQ;
                    end
                end
                REQ: begin
                    state_nxt = WAIT;
                end
                WAIT: begin
                    if (insfetch_task_done) begin
                        fill_we   = 1'b1;
                        state_nxt = last_word ? IDLE : REQ;
                    end
                end
                default: begin
                    state_nxt = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state <= IDLE;
        end else if (rdy_in) begin
            state <= state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Control/datapath registers (reset)
    // ------------------------------------------------------------------
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            valid      <= '0;
            is_ready   <= 1'b1;
            read_data  <= '0;
            fetch_addr <= '0;
            cnt        <= '0;
            req_off    <= '0;
            line_idx   <= '0;
            line_tag   <= '0;
        end else if (rdy_in) begin
            if (flush_pipline) begin
                // The partial line was already marked invalid at miss time.
                is_ready <= 1'b1;
            end else begin
                if (inv_en) begin
                    valid <= '0;
                end
                if (hit) begin
                    read_data <= data_mem[rd_idx][rd_off];
                end
                if (miss) begin
                    is_ready       <= 1'b0;
                    valid[rd_idx]  <= 1'b0;
                    line_idx       <= rd_idx;
                    line_tag       <= rd_tag;
                    req_off        <= rd_off;
                    cnt            <= '0;
                    fetch_addr     <= {read_addr[31:2+OFF_W], {(OFF_W+2){1'b0}}};
                end
                if (fill_we) begin
                    if (last_word) begin
                        valid[line_idx] <= 1'b1;
                        is_ready        <= 1'b1;
                        // The last word is still in flight to the array, so
                        // forward it directly when it is the requested one.
                        read_data <= (req_off == LAST_WORD) ?
                                     ins_fetched_from_memory_adaptor :
                                     data_mem[line_idx][req_off];
                    end else begin
                        cnt        <= cnt + CNT_W'(1);
                        fetch_addr <= fetch_addr + 32'd4;
                    end
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Data and tag arrays (not reset; guarded by valid bits)
    // ------------------------------------------------------------------
    always_ff @(posedge clk_in) begin
        if (rdy_in && !flush_pipline && fill_we) begin
            data_mem[line_idx][cnt] <= ins_fetched_from_memory_adaptor;
            if (last_word) begin
                tag_mem[line_idx] <= line_tag;
            end
        end
    end

    // Gating with rdy_in keeps the request a single-cycle pulse even when
    // the controller is frozen in REQ.
    assign request_ins_from_memory_adaptor           = (state == REQ) && rdy_in;
    assign insaddr_to_be_fetched_from_memory_adaptor = fetch_addr;

`ifdef ICACHE_STATS_EN
    // ------------------------------------------------------------------
    // Saturating lookup statistics
    // ------------------------------------------------------------------
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            hit_count  <= '0;
            miss_count <= '0;
        end else if (rdy_in) begin
            if (hit && (hit_count != 32'hFFFF_FFFF)) begin
                hit_count <= hit_count + 32'd1;
            end
            if (miss && (miss_count != 32'hFFFF_FFFF)) begin
                miss_count <= miss_count + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_line_instruction_cache.sv
// Directed testbench for line_instruction_cache (SETS=64, LINE_WORDS=4).
// Memory contents seen by the cache: word at address a = {16'hC0DE, a[15:0]}.

module tb_line_instruction_cache;

    logic        clk_in = 1'b0;
    logic        rst_n_in;
    logic        rdy_in;
    logic        flush_pipline;
    logic        invalidate_all;
    logic        is_reading;
    logic [31:0] read_addr;
    logic [31:0] read_data;
    logic        is_ready;
    logic        request;
    logic [31:0] fetch_addr;
    logic [31:0] ins;
    logic        done;
`ifdef ICACHE_STATS_EN
    logic [31:0] hit_count;
    logic [31:0] miss_count;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk_in = ~clk_in;

    line_instruction_cache #(.SETS(64), .LINE_WORDS(4)) dut (
        .clk_in                                    (clk_in),
        .rst_n_in                                  (rst_n_in),
        .rdy_in                                    (rdy_in),
        .flush_pipline                             (flush_pipline),
        .invalidate_all                            (invalidate_all),
        .is_reading                                (is_reading),
        .read_addr                                 (read_addr),
        .read_data                                 (read_data),
        .is_ready                                  (is_ready),
        .request_ins_from_memory_adaptor           (request),
        .insaddr_to_be_fetched_from_memory_adaptor (fetch_addr),
        .ins_fetched_from_memory_adaptor           (ins),
        .insfetch_task_done                        (done)
`ifdef ICACHE_STATS_EN
        ,
        .hit_count                                 (hit_count),
        .miss_count                                (miss_count)
`endif
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {16'hC0DE, a[15:0]};
    endfunction

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic do_read(input logic [31:0] a);
        is_reading = 1'b1;
        read_addr  = a;
        tick();
        is_reading = 1'b0;
        read_addr  = '0;
    endtask

    // Acts as the memory adaptor for nwords words of a refill starting at base.
    task automatic serve_line(input logic [31:0] base, input int nwords);
        int waited;
        for (int w = 0; w < nwords; w++) begin
            waited = 0;
            while (request !== 1'b1 && waited < 20) begin
                tick();
                waited++;
            end
            n_checks++;
            if (request !== 1'b1) begin
                n_fail++;
                $display("FAIL serve_req_timeout base=%h word=%0d: request=%b required 1", base, w, request);
                return;
            end
            n_checks++;
            if (fetch_addr !== base + 32'(4 * w)) begin
                n_fail++;
                $display("FAIL serve_addr word=%0d: got %h required %h", w, fetch_addr, base + 32'(4 * w));
            end
            tick();
            n_checks++;
            if (request !== 1'b0) begin
                n_fail++;
                $display("FAIL serve_req_pulse word=%0d: request=%b required 0", w, request);
            end
            done = 1'b1;
            ins  = mem_word(base + 32'(4 * w));
            tick();
            done = 1'b0;
            ins  = '0;
        end
    endtask

    task automatic test_reset();
        #12;
        n_checks++;
        if (is_ready !== 1'b1 || request !== 1'b0 || read_data !== 32'h0 || fetch_addr !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_values: is_ready=%b request=%b read_data=%h fetch=%h required 1 0 0 0",
                     is_ready, request, read_data, fetch_addr);
        end
        rst_n_in = 1'b1;
        tick();
        n_checks++;
        if (is_ready !== 1'b1 || request !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_release: is_ready=%b request=%b required 1 0", is_ready, request);
        end
    endtask

    task automatic test_cold_fill_hit();
        do_read(32'h104);
        n_checks++;
        if (is_ready !== 1'b0 || request !== 1'b1) begin
            n_fail++;
            $display("FAIL cold_miss: is_ready=%b request=%b required 0 1", is_ready, request);
        end
        serve_line(32'h100, 4);
        n_checks++;
        if (is_ready !== 1'b1 || read_data !== 32'hC0DE_0104) begin
            n_fail++;
            $display("FAIL cold_fill_data: is_ready=%b read_data=%h required 1 c0de0104", is_ready, read_data);
        end
        do_read(32'h10C);
        n_checks++;
        if (is_ready !== 1'b1 || read_data !== 32'hC0DE_010C || request !== 1'b0) begin
            n_fail++;
            $display("FAIL hit_10c: is_ready=%b read_data=%h request=%b required 1 c0de010c 0",
                     is_ready, read_data, request);
        end
        tick();
        n_checks++;
        if (request !== 1'b0 || is_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL hit_no_request: request=%b is_ready=%b required 0 1", request, is_ready);
        end
        // Requested word is the last of the line: must be forwarded.
        do_read(32'h20C);
        serve_line(32'h200, 4);
        n_checks++;
        if (is_ready !== 1'b1 || read_data !== 32'hC0DE_020C) begin
            n_fail++;
            $display("FAIL forward_last: is_ready=%b read_data=%h required 1 c0de020c", is_ready, read_data);
        end
        do_read(32'h204);
        n_checks++;
        if (is_ready !== 1'b1 || read_data !== 32'hC0DE_0204) begin
            n_fail++;
            $display("FAIL hit_204: is_ready=%b read_data=%h required 1 c0de0204", is_ready, read_data);
        end
    endtask

    task automatic test_conflict();
        do_read(32'h500);
        n_checks++;
        if (is_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL conflict_miss_500: is_ready=%b required 0", is_ready);
        end
        serve_line(32'h500, 4);
        n_checks++;
        if (read_data !== 32'hC0DE_0500) begin
            n_fail++;
            $display("FAIL conflict_data_500: read_data=%h required c0de0500", read_data);
        end
        do_read(32'h100);
        n_checks++;
        if (is_ready !== 1'b0 || request !== 1'b1) begin
            n_fail++;
            $display("FAIL conflict_remiss_100: is_ready=%b request=%b required 0 1", is_ready, request);
        end
    endtask

    // Continues the 0x100 refill left open by test_conflict.
    task automatic test_flush();
        serve_line(32'h100, 2);
        n_checks++;
        if (request !== 1'b1 || fetch_addr !== 32'h108) begin
            n_fail++;
            $display("FAIL flush_third_req: request=%b fetch=%h required 1 00000108", request, fetch_addr);
        end
        tick();
        flush_pipline = 1'b1;
        done          = 1'b1;
        ins           = 32'hDEAD_BEEF;
        tick();
        flush_pipline = 1'b0;
        n_checks++;
        if (is_ready !== 1'b1 || request !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_idle: is_ready=%b request=%b required 1 0", is_ready, request);
        end
        tick();
        done = 1'b0;
        ins  = '0;
        n_checks++;
        if (is_ready !== 1'b1 || request !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_late_done: is_ready=%b request=%b required 1 0", is_ready, request);
        end
        do_read(32'h100);
        n_checks++;
        if (is_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_partial_invalid: is_ready=%b required 0", is_ready);
        end
        serve_line(32'h100, 4);
        n_checks++;
        if (is_ready !== 1'b1 || read_data !== 32'hC0DE_0100) begin
            n_fail++;
            $display("FAIL flush_refill_data: is_ready=%b read_data=%h required 1 c0de0100", is_ready, read_data);
        end
    endtask

    task automatic test_invalidate();
        do_read(32'h000);
        serve_line(32'h000, 4);
        invalidate_all = 1'b1;
        tick();
        invalidate_all = 1'b0;
        n_checks++;
        if (is_ready !== 1'b1 || request !== 1'b0) begin
            n_fail++;
            $display("FAIL inv_pulse: is_ready=%b request=%b required 1 0", is_ready, request);
        end
        do_read(32'h000);
        n_checks++;
        if (is_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL inv_miss_000: is_ready=%b required 0", is_ready);
        end
        serve_line(32'h000, 4);
        do_read(32'h100);
        n_checks++;
        if (is_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL inv_miss_100: is_ready=%b required 0", is_ready);
        end
        serve_line(32'h100, 4);
        // Both lines valid again; invalidate together with a read of 0x000.
        invalidate_all = 1'b1;
        do_read(32'h000);
        invalidate_all = 1'b0;
        n_checks++;
        if (is_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL inv_simultaneous_miss: is_ready=%b required 0", is_ready);
        end
        serve_line(32'h000, 4);
        n_checks++;
        if (read_data !== 32'hC0DE_0000) begin
            n_fail++;
            $display("FAIL inv_refill_data: read_data=%h required c0de0000", read_data);
        end
        do_read(32'h100);
        n_checks++;
        if (is_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL inv_simultaneous_clears_100: is_ready=%b required 0", is_ready);
        end
        serve_line(32'h100, 4);
    endtask

    task automatic test_rdy_freeze();
        rdy_in     = 1'b0;
        is_reading = 1'b1;
        read_addr  = 32'h700;
        tick();
        tick();
        is_reading = 1'b0;
        n_checks++;
        if (is_ready !== 1'b1 || request !== 1'b0) begin
            n_fail++;
            $display("FAIL rdy_ignore_read: is_ready=%b request=%b required 1 0", is_ready, request);
        end
        rdy_in = 1'b1;
        do_read(32'h700);
        rdy_in = 1'b0;
        #1;
        n_checks++;
        if (request !== 1'b0 || is_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL rdy_freeze_req: request=%b is_ready=%b required 0 0", request, is_ready);
        end
        tick();
        tick();
        rdy_in = 1'b1;
        #1;
        n_checks++;
        if (request !== 1'b1 || fetch_addr !== 32'h700) begin
            n_fail++;
            $display("FAIL rdy_resume_req: request=%b fetch=%h required 1 00000700", request, fetch_addr);
        end
        serve_line(32'h700, 4);
        n_checks++;
        if (read_data !== 32'hC0DE_0700) begin
            n_fail++;
            $display("FAIL rdy_fill_data: read_data=%h required c0de0700", read_data);
        end
    endtask

    task automatic test_reset_in_wait();
        do_read(32'h240);
        tick();
        n_checks++;
        if (request !== 1'b0 || is_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_wait_state: request=%b is_ready=%b required 0 0", request, is_ready);
        end
        rst_n_in = 1'b0;
        #1;
        n_checks++;
        if (is_ready !== 1'b1 || request !== 1'b0 || read_data !== 32'h0 || fetch_addr !== 32'h0) begin
            n_fail++;
            $display("FAIL rst_in_wait: is_ready=%b request=%b read_data=%h fetch=%h required 1 0 0 0",
                     is_ready, request, read_data, fetch_addr);
        end
        #1;
        rst_n_in = 1'b1;
        tick();
        do_read(32'h104);
        n_checks++;
        if (is_ready !== 1'b0 || request !== 1'b1 || fetch_addr !== 32'h100) begin
            n_fail++;
            $display("FAIL rst_then_miss: is_ready=%b request=%b fetch=%h required 0 1 00000100",
                     is_ready, request, fetch_addr);
        end
        serve_line(32'h100, 4);
        n_checks++;
        if (read_data !== 32'hC0DE_0104) begin
            n_fail++;
            $display("FAIL rst_refill_data: read_data=%h required c0de0104", read_data);
        end
    endtask

`ifdef ICACHE_STATS_EN
    task automatic test_stats();
        rst_n_in = 1'b0;
        #1;
        rst_n_in = 1'b1;
        n_checks++;
        if (hit_count !== 32'd0 || miss_count !== 32'd0) begin
            n_fail++;
            $display("FAIL stats_reset: hit=%0d miss=%0d required 0 0", hit_count, miss_count);
        end
        tick();
        do_read(32'h0);
        serve_line(32'h0, 4);
        do_read(32'h4);
        do_read(32'h8);
        do_read(32'hC);
        n_checks++;
        if (hit_count !== 32'd3 || miss_count !== 32'd1) begin
            n_fail++;
            $display("FAIL stats_counts: hit=%0d miss=%0d required 3 1", hit_count, miss_count);
        end
    endtask
`endif

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n_in       = 1'b0;
        rdy_in         = 1'b1;
        flush_pipline  = 1'b0;
        invalidate_all = 1'b0;
        is_reading     = 1'b0;
        read_addr      = '0;
        ins            = '0;
        done           = 1'b0;

        test_reset();
        test_cold_fill_hit();
        test_conflict();
        test_flush();
        test_invalidate();
        test_rdy_freeze();
        test_reset_in_wait();
`ifdef ICACHE_STATS_EN
        test_stats();
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
